pfmt: RTL

Physical-to-virtual fixed mapper: the reverse of the fixed virtual-to-physical segment translation. It takes physical addresses captured on the memory bus, for example by the debug or trace unit, and reconstructs the kseg0, kseg1 or kuseg virtual address the core would have issued. Requests enter through a valid/ready port, are translated on entry, buffered in a small FIFO and drained through a second valid/ready port. Per-segment saturating counters record the drained traffic.

---
 rtl/pfmt_pkg.sv | 46 ++++
 rtl/pfmt_fifo.sv | 56 +++++
 rtl/pfmt.sv | 95 +++++++++
 3 files changed

// File: rtl/pfmt_pkg.sv
// Shared segment codes, address map constants and the physical-to-virtual
// translation rules used by the pfmt block.
package pfmt_pkg;

  localparam logic [1:0] SEG_KUSEG = 2'd0;
  localparam logic [1:0] SEG_KSEG0 = 2'd1;
  localparam logic [1:0] SEG_KSEG1 = 2'd2;
  localparam logic [1:0] SEG_KHIGH = 2'd3;

  localparam logic [31:0] KSEG0_BASE  = 32'h8000_0000;
  localparam logic [31:0] KSEG1_BASE  = 32'hA000_0000;
  localparam logic [31:0] KSEG01_SPAN = 32'h2000_0000;
  localparam logic [31:0] KUSEG_LIMIT = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] vaddr;
    logic [1:0]  seg;
    logic        err;
  } xlate_t;

  localparam int XLATE_W = $bits(xlate_t);

  // Kernel accesses to the low 512 MB fold back into kseg0/kseg1; anything
  // else keeps its address and is only classified.
  function automatic xlate_t translate(input logic [31:0] paddr,
                                       input logic        uncached,
                                       input logic        user);
    xlate_t r;
    r.vaddr = paddr;
    r.seg   = SEG_KUSEG;
    r.err   = 1'b0;
    if (user) begin
      if (paddr >= KUSEG_LIMIT) begin
        r.seg = SEG_KHIGH;
        r.err = 1'b1;
      end
    end else if (paddr < KSEG01_SPAN) begin
      r.vaddr = paddr | (uncached ? KSEG1_BASE : KSEG0_BASE);
      r.seg   = uncached ? SEG_KSEG1 : SEG_KSEG0;
    end else if (paddr >= KUSEG_LIMIT) begin
      r.seg = SEG_KHIGH;
    end
    return r;
  endfunction

endpackage

// File: rtl/pfmt_fifo.sv
// Parameterised WIDTH x DEPTH synchronous FIFO with full/empty flags.
// The read port shows zero while empty so a freshly reset FIFO drives zeros.
module pfmt_fifo #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == CNT_FULL);
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_rdata  = o_empty ? '0 : r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_ONE;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_wdata;
  end

endmodule

// File: rtl/pfmt.sv
// Physical-to-virtual fixed mapper: translates on entry, queues results in a
// small FIFO and keeps saturating per-segment counters of drained traffic.
module pfmt
  import pfmt_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_paddr,
  input  logic             in_uncached,
  input  logic             in_user,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_vaddr,
  output logic [1:0]       out_seg,
  output logic             out_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_kuseg,
  output logic [CNT_W-1:0] cnt_kseg0,
  output logic [CNT_W-1:0] cnt_kseg1,
  output logic [CNT_W-1:0] cnt_err
);

  xlate_t             w_inXlate;
  xlate_t             w_head;
  logic [XLATE_W-1:0] w_headBits;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [CNT_W-1:0]   r_cntKuseg;
  logic [CNT_W-1:0]   r_cntKseg0;
  logic [CNT_W-1:0]   r_cntKseg1;
  logic [CNT_W-1:0]   r_cntErr;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign w_inXlate = translate(in_paddr, in_uncached, in_user);
  assign in_ready  = !w_full && resetn;
  assign w_push    = in_valid && in_ready;
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;

  pfmt_fifo #(
    .WIDTH (XLATE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_wdata (w_inXlate),
    .i_pop   (w_pop),
    .o_rdata (w_headBits),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head    = xlate_t'(w_headBits);
  assign out_vaddr = w_head.vaddr;
  assign out_seg   = w_head.seg;
  assign out_err   = w_head.err;

  // Errors are counted only as errors; KHIGH without error has no counter.
  always_ff @(posedge clk) begin
    if (!resetn || cnt_clr) begin
      r_cntKuseg <= '0;
      r_cntKseg0 <= '0;
      r_cntKseg1 <= '0;
      r_cntErr   <= '0;
    end else if (w_pop) begin
      if (w_head.err) begin
        r_cntErr <= satInc(r_cntErr);
      end else begin
        case (w_head.seg)
          SEG_KUSEG: r_cntKuseg <= satInc(r_cntKuseg);
          SEG_KSEG0: r_cntKseg0 <= satInc(r_cntKseg0);
          SEG_KSEG1: r_cntKseg1 <= satInc(r_cntKseg1);
          default:   r_cntErr   <= r_cntErr;
        endcase
      end
    end
  end

  assign cnt_kuseg = r_cntKuseg;
  assign cnt_kseg0 = r_cntKseg0;
  assign cnt_kseg1 = r_cntKseg1;
  assign cnt_err   = r_cntErr;

endmodule
